stream_lane_deserializer: RTL

STREAM_LANE_DESERIALIZER -- requirements
Module: stream_lane_deserializer

---
 rtl/fft_stream_pkg.sv | 26 ++
 rtl/frame_bank.sv | 31 +++
 rtl/stream_lane_deserializer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fft_stream_pkg.sv
// Shared types and default geometry for the streaming frame deserializer.
package fft_stream_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_NPOINT = 16;
  localparam int DEF_LANES  = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  // Complete control state of the ping-pong pair; out_bank names the bank
  // whose beat currently sits in the output register.
  typedef struct packed {
    bank_state_t [1:0] bank;
    logic              wr_bank;
    logic              rd_bank;
    logic              out_bank;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '0;

endpackage

// File: rtl/frame_bank.sv
// One frame of storage: serial write port, LANES-wide strided combinational read.
module frame_bank #(
  parameter int DATA_W = 32,
  parameter int NPOINT = 16,
  parameter int LANES  = 4
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(NPOINT)-1:0]     waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [$clog2(NPOINT/LANES)-1:0] rbeat,
  output logic [LANES*DATA_W-1:0]       rdata
);

  localparam int D     = NPOINT / LANES;
  localparam int IDX_W = $clog2(NPOINT);

  logic [DATA_W-1:0] mem [NPOINT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Lane k of beat j is sample k*D + j.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [IDX_W-1:0] ridx;
    assign ridx = IDX_W'(k * D) + IDX_W'(rbeat);
    assign rdata[k*DATA_W +: DATA_W] = mem[ridx];
  end

endmodule

// File: rtl/stream_lane_deserializer.sv
// Serial sample stream to LANES-wide beats through two ping-pong frame banks.
module stream_lane_deserializer
  import fft_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NPOINT = DEF_NPOINT,
  parameter int LANES  = DEF_LANES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last
);

  localparam int D      = NPOINT / LANES;
  localparam int IDX_W  = $clog2(NPOINT);
  localparam int BEAT_W = $clog2(D);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NPOINT - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(D - 1);

  if ((NPOINT < 4) || (NPOINT > 1024) || ((NPOINT & (NPOINT - 1)) != 0)) begin : g_bad_npoint
    $error("NPOINT must be a power of two in 4..1024");
  end
  if ((LANES < 1) || ((LANES & (LANES - 1)) != 0) || (LANES >= NPOINT)) begin : g_bad_lanes
    $error("LANES must be a power of two smaller than NPOINT");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("DATA_W must be at least 1");
  end

  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both high; in_ready depends only on registered state.
  ctrl_t                   ctrl_q, ctrl_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [BEAT_W-1:0]       rd_beat_q, rd_beat_d;
  logic [LANES*DATA_W-1:0] out_data_d;
  logic                    out_valid_d, out_first_d, out_last_d;
  logic [LANES*DATA_W-1:0] rdata [2];
  logic                    wr_fire, out_fire, load;

  assign in_ready = (ctrl_q.bank[ctrl_q.wr_bank] == BANK_EMPTY) ||
                    (ctrl_q.bank[ctrl_q.wr_bank] == BANK_FILLING);
  assign wr_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Beat 0 needs a full bank; later beats continue the bank being drained.
  assign load = (!out_valid || out_fire) &&
                ((rd_beat_q == '0) ? (ctrl_q.bank[ctrl_q.rd_bank] == BANK_FULL)
                                   : (ctrl_q.bank[ctrl_q.rd_bank] == BANK_DRAINING));

  frame_bank #(.DATA_W(DATA_W), .NPOINT(NPOINT), .LANES(LANES)) u_bank0 (
    .clk   (clk),
    .we    (wr_fire && !flush && (ctrl_q.wr_bank == 1'b0)),
    .waddr (wr_idx_q),
    .wdata (in_data),
    .rbeat (rd_beat_q),
    .rdata (rdata[0])
  );

  frame_bank #(.DATA_W(DATA_W), .NPOINT(NPOINT), .LANES(LANES)) u_bank1 (
    .clk   (clk),
    .we    (wr_fire && !flush && (ctrl_q.wr_bank == 1'b1)),
    .waddr (wr_idx_q),
    .wdata (in_data),
    .rbeat (rd_beat_q),
    .rdata (rdata[1])
  );

  always_comb begin
    ctrl_d      = ctrl_q;
    wr_idx_d    = wr_idx_q;
    rd_beat_d   = rd_beat_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_first_d = out_first;
    out_last_d  = out_last;
    if (flush) begin
      ctrl_d      = CTRL_RESET;
      wr_idx_d    = '0;
      rd_beat_d   = '0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      out_first_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_idx_q == LAST_IDX) begin
          ctrl_d.bank[ctrl_q.wr_bank] = BANK_FULL;
          ctrl_d.wr_bank              = ~ctrl_q.wr_bank;
          wr_idx_d                    = '0;
        end else begin
          ctrl_d.bank[ctrl_q.wr_bank] = BANK_FILLING;
          wr_idx_d                    = wr_idx_q + IDX_W'(1);
        end
      end
      if (out_fire) begin
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        if (out_last) ctrl_d.bank[ctrl_q.out_bank] = BANK_EMPTY;
      end
      // The bank that is drained is never the one being written, so both
      // updates above and below can land in the same cycle.
      if (load) begin
        out_valid_d     = 1'b1;
        out_data_d      = rdata[ctrl_q.rd_bank];
        out_first_d     = (rd_beat_q == '0);
        out_last_d      = (rd_beat_q == LAST_BEAT);
        ctrl_d.out_bank = ctrl_q.rd_bank;
        if (rd_beat_q == '0) ctrl_d.bank[ctrl_q.rd_bank] = BANK_DRAINING;
        if (rd_beat_q == LAST_BEAT) begin
          rd_beat_d      = '0;
          ctrl_d.rd_bank = ~ctrl_q.rd_bank;
        end else begin
          rd_beat_d = rd_beat_q + BEAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= CTRL_RESET;
      wr_idx_q  <= '0;
      rd_beat_q <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      wr_idx_q  <= wr_idx_d;
      rd_beat_q <= rd_beat_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_first <= out_first_d;
      out_last  <= out_last_d;
    end
  end

endmodule
